chorus_mod_delay: RTL



---
 rtl/chorus_mod_delay.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/chorus_mod_delay.sv
// Modulated delay line: stores each strobed sample in a 512-entry RAM, reads back an
// LFO-swept tap pair and linearly interpolates; result 5 cycles after strobe, strobes dropped while busy.
module chorus_mod_delay #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] In1,
  input  logic        [ADDR_W-1:0] base_delay,
  input  logic        [5:0]        mod_depth,
  input  logic        [15:0]       mod_rate,
  output logic                     ce_out,
  output logic signed [DATA_W-1:0] Out1,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] D_MAX = (ADDR_W+1)'(DEPTH - 2);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RD_A   = 3'd3;
  localparam logic [2:0] S_RD_B   = 3'd4;
  localparam logic [2:0] S_CAP    = 3'd5;
  localparam logic [2:0] S_INTERP = 3'd6;

  logic [2:0]               state;
  logic [ADDR_W-1:0]        clr_addr;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [15:0]              phase;
  logic [15:0]              phase_q;
  logic [15:0]              rate_q;
  logic [ADDR_W-1:0]        base_q;
  logic [5:0]               depth_q;
  logic signed [DATA_W-1:0] sample_q;
  logic signed [DATA_W-1:0] s0;
  logic signed [DATA_W-1:0] rdata;
  logic [DATA_W-1:0]        mem [DEPTH];

  // Triangle LFO from the phase latched before this sample's increment
  logic [14:0] tri_val;
  logic [20:0] lfo_off;
  logic [5:0]  off_int;
  logic [7:0]  frac;
  assign tri_val = phase_q[15] ? ~phase_q[14:0] : phase_q[14:0];
  assign lfo_off = {6'd0, tri_val} * {15'd0, depth_q};
  assign off_int = lfo_off[20:15];
  assign frac    = lfo_off[14:7];

  // B is one sample older than A; clamping to DEPTH-2 keeps B off the slot just written
  logic [ADDR_W:0]   d_sum;
  logic [ADDR_W:0]   d_eff;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  assign d_sum  = {1'b0, base_q} + {{(ADDR_W-5){1'b0}}, off_int};
  assign d_eff  = (d_sum > D_MAX) ? D_MAX : d_sum;
  assign addr_a = wr_ptr - d_eff[ADDR_W-1:0];
  assign addr_b = addr_a - {{(ADDR_W-1){1'b0}}, 1'b1};

  // rdata holds s1 during CAP; result stays between s0 and s1 so truncation is exact
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+9:0] prod;
  logic signed [DATA_W-1:0] interp;
  assign diff   = {rdata[DATA_W-1], rdata} - {s0[DATA_W-1], s0};
  assign prod   = $signed({{9{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+2){1'b0}}, frac});
  assign interp = s0 + prod[DATA_W+7:8];

  logic unused_bits;
  assign unused_bits = ^{prod[DATA_W+9:DATA_W+8], prod[7:0], lfo_off[6:0], d_eff[ADDR_W]};

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdat;
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_a;
    ram_wdat = '0;
    case (state)
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
      end
      S_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = wr_ptr;
        ram_wdat = sample_q;
      end
      S_RD_B:  ram_addr = addr_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdat;
    rdata <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && clk_enable) begin
      sample_q <= In1;
      base_q   <= base_delay;
      depth_q  <= mod_depth;
      rate_q   <= mod_rate;
      phase_q  <= phase;
    end
    if (state == S_RD_B) s0 <= rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      wr_ptr   <= '0;
      phase    <= '0;
      Out1     <= '0;
      ce_out   <= 1'b0;
    end else begin
      ce_out <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state <= S_IDLE;
        end
        S_IDLE:  if (clk_enable) state <= S_WRITE;
        S_WRITE: begin
          phase <= phase + rate_q;
          state <= S_RD_A;
        end
        S_RD_A:  state <= S_RD_B;
        S_RD_B:  state <= S_CAP;
        S_CAP: begin
          Out1   <= interp;
          ce_out <= 1'b1;
          state  <= S_INTERP;
        end
        S_INTERP: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
